// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight; registered outputs.
// req->gnt 1 cycle, req->rvalid >= 3 cycles; requesters hold req until gnt, memory stalls via mem_ready/mem_rvalid.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [1:0]        dm_store_type,
    input  logic [2:0]        dm_load_type,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_last_dm, w_last_dm_nxt;
    logic              r_own_dm, w_own_dm_nxt;
    logic              r_we, w_we_nxt;
    logic              r_mis, w_mis_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic [2:0]        r_lt, w_lt_nxt;

    logic              r_if_gnt, w_if_gnt_nxt;
    logic              r_if_rvalid, w_if_rvalid_nxt;
    logic [31:0]       r_if_rdata, w_if_rdata_nxt;
    logic              r_dm_gnt, w_dm_gnt_nxt;
    logic              r_dm_rvalid, w_dm_rvalid_nxt;
    logic [31:0]       r_dm_rdata, w_dm_rdata_nxt;
    logic              r_dm_err, w_dm_err_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]        r_mem_be, w_mem_be_nxt;
    logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;

    logic              w_st_byte, w_st_half, w_ld_byte, w_ld_half;
    logic              w_is_byte, w_is_half, w_mis, w_pick_dm;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rd_shift, w_load;
    logic [15:0]       w_rd_half;
    logic              w_unused;

    assign w_unused = ^if_addr[1:0];

    // Unknown type encodings fall through to the word case everywhere below.
    assign w_st_byte = (dm_store_type == 2'b00);
    assign w_st_half = (dm_store_type == 2'b01);
    assign w_ld_byte = (dm_load_type == 3'b000) || (dm_load_type == 3'b100);
    assign w_ld_half = (dm_load_type == 3'b001) || (dm_load_type == 3'b101);
    assign w_is_byte = dm_we ? w_st_byte : w_ld_byte;
    assign w_is_half = dm_we ? w_st_half : w_ld_half;
    assign w_mis     = w_is_half ? dm_addr[0] : (!w_is_byte && (dm_addr[1:0] != 2'b00));

    // last_grant resets to fetch, so the first tie goes to the data side.
    assign w_pick_dm = dm_req && (!if_req || !FAIR || !r_last_dm);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = dm_wdata;
        if (w_st_byte) begin
            w_be    = 4'b0001 << dm_addr[1:0];
            w_wdata = {4{dm_wdata[7:0]}};
        end else if (w_st_half) begin
            w_be    = dm_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{dm_wdata[15:0]}};
        end
    end

    assign w_rd_shift = mem_rdata >> {r_off, 3'b000};
    assign w_rd_half  = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_lt)
            3'b000:  w_load = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            3'b100:  w_load = {24'd0, w_rd_shift[7:0]};
            3'b001:  w_load = {{16{w_rd_half[15]}}, w_rd_half};
            3'b101:  w_load = {16'd0, w_rd_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_dm_nxt   = r_last_dm;
        w_own_dm_nxt    = r_own_dm;
        w_we_nxt        = r_we;
        w_mis_nxt       = r_mis;
        w_off_nxt       = r_off;
        w_lt_nxt        = r_lt;
        w_if_gnt_nxt    = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_gnt_nxt    = 1'b0;
        w_dm_rvalid_nxt = 1'b0;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_dm_err_nxt    = 1'b0;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (w_pick_dm) begin
                    w_dm_gnt_nxt  = 1'b1;
                    w_last_dm_nxt = 1'b1;
                    w_own_dm_nxt  = 1'b1;
                    w_we_nxt      = dm_we;
                    w_mis_nxt     = w_mis;
                    w_off_nxt     = dm_addr[1:0];
                    w_lt_nxt      = dm_load_type;
                    w_state_nxt   = ISSUE;
                    // A misaligned access never reaches the memory bus.
                    if (!w_mis) begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = dm_we;
                        w_mem_addr_nxt  = {dm_addr[ADDR_W-1:2], 2'b00};
                        w_mem_be_nxt    = dm_we ? w_be : 4'b0000;
                        w_mem_wdata_nxt = dm_we ? w_wdata : 32'd0;
                    end
                end else if (if_req) begin
                    w_if_gnt_nxt    = 1'b1;
                    w_last_dm_nxt   = 1'b0;
                    w_own_dm_nxt    = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_mis_nxt       = 1'b0;
                    w_off_nxt       = 2'b00;
                    w_lt_nxt        = 3'b010;
                    w_state_nxt     = ISSUE;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = {if_addr[ADDR_W-1:2], 2'b00};
                    w_mem_be_nxt    = 4'b0000;
                    w_mem_wdata_nxt = 32'd0;
                end
            end
            ISSUE: begin
                if (r_mis) begin
                    w_dm_rvalid_nxt = 1'b1;
                    w_dm_err_nxt    = 1'b1;
                    w_dm_rdata_nxt  = 32'd0;
                    w_state_nxt     = IDLE;
                end else if (mem_ready) begin
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_be_nxt    = 4'b0000;
                    w_mem_wdata_nxt = 32'd0;
                    w_state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (r_own_dm) begin
                        w_dm_rvalid_nxt = 1'b1;
                        w_dm_rdata_nxt  = r_we ? 32'd0 : w_load;
                    end else begin
                        w_if_rvalid_nxt = 1'b1;
                        w_if_rdata_nxt  = mem_rdata;
                    end
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_last_dm   <= 1'b0;
            r_own_dm    <= 1'b0;
            r_we        <= 1'b0;
            r_mis       <= 1'b0;
            r_off       <= 2'b00;
            r_lt        <= 3'b000;
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_gnt    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= 32'd0;
            r_dm_err    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_dm   <= w_last_dm_nxt;
            r_own_dm    <= w_own_dm_nxt;
            r_we        <= w_we_nxt;
            r_mis       <= w_mis_nxt;
            r_off       <= w_off_nxt;
            r_lt        <= w_lt_nxt;
            r_if_gnt    <= w_if_gnt_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_gnt    <= w_dm_gnt_nxt;
            r_dm_rvalid <= w_dm_rvalid_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_dm_err    <= w_dm_err_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_gnt    = r_dm_gnt;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_err    = r_dm_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction table with an rvalid scoreboard, plus reset-abort and tie sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [1:0]  dm_store_type;
    logic [2:0]  dm_load_type;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, mem_req, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b, dm_err_b, mem_req_b, mem_we_b;
    logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_be_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .FAIR(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_store_type(dm_store_type), .dm_load_type(dm_load_type),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .FAIR(1'b0)) u_dut_dpri (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_store_type(dm_store_type), .dm_load_type(dm_load_type),
        .dm_gnt(dm_gnt_b), .dm_rvalid(dm_rvalid_b), .dm_rdata(dm_rdata_b), .dm_err(dm_err_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_be(mem_be_b), .mem_wdata(mem_wdata_b),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [31:0] mrd;
        int          stall;
        bit          mreq;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    typedef struct {
        bit          dm;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   sb_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, mem_req, mem_we, mem_be}, 64'd0);
        check({tag, "_if_rdata"}, if_rdata, 64'd0);
        check({tag, "_dm_rdata"}, dm_rdata, 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    endtask

    task automatic check_mem(input vec_t v, input string tag);
        check({tag, "_mem_req"}, mem_req, 64'd1);
        check({tag, "_mem_addr"}, mem_addr, v.maddr);
        check({tag, "_mem_we"}, mem_we, v.we);
        check({tag, "_mem_be"}, mem_be, v.be);
        if (v.we) check({tag, "_mem_wdata"}, mem_wdata, v.mwd);
    endtask

    // Scoreboard: every rvalid pops the oldest expected completion.
    always @(negedge clk) begin
        if (sb_en && reset_n && (if_rvalid || dm_rvalid)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rvalid: got if_rvalid=%b dm_rvalid=%b, required none", if_rvalid, dm_rvalid);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_side", {if_rvalid, dm_rvalid}, e.dm ? 64'd1 : 64'd2);
                check("sb_rdata", e.dm ? dm_rdata : if_rdata, e.rd);
                if (e.dm) check("sb_err", dm_err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int lat;
        int rv_seen;
        int n0, n1, dup;
        bit g0[4];
        bit g1[4];

        reset_n = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        dm_store_type = 0; dm_load_type = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        #1;
        check_reset("por");

        //                 dm we addr         wdata         st     lt      mrd           st mreq maddr      be       mwd           rd            err
        vecs.push_back(vec_t'{0, 0, 32'h100, 32'h0,        2'b00, 3'b000, 32'h00500093, 0, 1, 32'h100, 4'b0000, 32'h0,        32'h00500093, 0});
        vecs.push_back(vec_t'{1, 1, 32'h203, 32'h000000AB, 2'b00, 3'b000, 32'h0,        3, 1, 32'h200, 4'b1000, 32'hABABABAB, 32'h0,        0});
        vecs.push_back(vec_t'{1, 0, 32'h301, 32'h0,        2'b00, 3'b000, 32'h1234F678, 0, 1, 32'h300, 4'b0000, 32'h0,        32'hFFFFFFF6, 0});
        vecs.push_back(vec_t'{1, 0, 32'h301, 32'h0,        2'b00, 3'b100, 32'h1234F678, 0, 1, 32'h300, 4'b0000, 32'h0,        32'h000000F6, 0});
        vecs.push_back(vec_t'{1, 0, 32'h302, 32'h0,        2'b00, 3'b001, 32'h1234F678, 0, 1, 32'h300, 4'b0000, 32'h0,        32'h00001234, 0});
        vecs.push_back(vec_t'{1, 1, 32'h402, 32'h11111111, 2'b10, 3'b000, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1});
        vecs.push_back(vec_t'{1, 1, 32'h206, 32'h0000BEEF, 2'b01, 3'b000, 32'h0,        1, 1, 32'h204, 4'b1100, 32'hBEEFBEEF, 32'h0,        0});
        vecs.push_back(vec_t'{1, 0, 32'h400, 32'h0,        2'b00, 3'b010, 32'hDEADBEEF, 2, 1, 32'h400, 4'b0000, 32'h0,        32'hDEADBEEF, 0});
        vecs.push_back(vec_t'{1, 0, 32'h300, 32'h0,        2'b00, 3'b101, 32'h1234F678, 0, 1, 32'h300, 4'b0000, 32'h0,        32'h0000F678, 0});
        vecs.push_back(vec_t'{1, 0, 32'h300, 32'h0,        2'b00, 3'b001, 32'h1234F678, 0, 1, 32'h300, 4'b0000, 32'h0,        32'hFFFFF678, 0});
        vecs.push_back(vec_t'{1, 0, 32'h301, 32'h0,        2'b00, 3'b001, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1});
        vecs.push_back(vec_t'{1, 1, 32'h200, 32'h12345678, 2'b00, 3'b000, 32'h0,        0, 1, 32'h200, 4'b0001, 32'h78787878, 32'h0,        0});
        vecs.push_back(vec_t'{0, 0, 32'h104, 32'h0,        2'b00, 3'b000, 32'h11223344, 2, 1, 32'h104, 4'b0000, 32'h0,        32'h11223344, 0});
        vecs.push_back(vec_t'{1, 1, 32'h400, 32'hCAFEBABE, 2'b10, 3'b000, 32'h0,        0, 1, 32'h400, 4'b1111, 32'hCAFEBABE, 32'h0,        0});
        vecs.push_back(vec_t'{1, 1, 32'h401, 32'h0,        2'b11, 3'b000, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1});
        vecs.push_back(vec_t'{1, 0, 32'h303, 32'h0,        2'b00, 3'b000, 32'h80000000, 0, 1, 32'h300, 4'b0000, 32'h0,        32'hFFFFFF80, 0});
        vecs.push_back(vec_t'{1, 0, 32'h303, 32'h0,        2'b00, 3'b101, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1});
        vecs.push_back(vec_t'{1, 0, 32'h304, 32'h0,        2'b00, 3'b011, 32'h0BADF00D, 0, 1, 32'h304, 4'b0000, 32'h0,        32'h0BADF00D, 0});

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        sb_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            if (v.dm) begin
                dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
                dm_store_type = v.st; dm_load_type = v.lt;
            end else begin
                if_req = 1; if_addr = v.addr;
            end
            sb_q.push_back(exp_t'{v.dm, v.rd, v.err});
            got = 0;
            lat = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (v.dm ? dm_gnt : if_gnt) begin
                    got = 1;
                    lat = k;
                    break;
                end
            end
            check($sformatf("v%0d_gnt", i), got, 64'd1);
            check($sformatf("v%0d_gnt_lat", i), lat, 64'd0);
            check($sformatf("v%0d_other_gnt", i), v.dm ? if_gnt : dm_gnt, 64'd0);
            if_req = 0;
            dm_req = 0;
            if (!v.mreq) begin
                check($sformatf("v%0d_mis_mem_req", i), mem_req, 64'd0);
                @(negedge clk);
                check($sformatf("v%0d_mis_mem_req2", i), mem_req, 64'd0);
                check($sformatf("v%0d_mis_rv_lat", i), dm_rvalid, 64'd1);
            end else begin
                check_mem(v, $sformatf("v%0d_issue", i));
                mem_ready = 0;
                // Stray mem_rvalid while still issuing must be ignored.
                mem_rvalid = (v.stall > 0);
                mem_rdata = 32'hDEAD0000;
                for (int s = 0; s < v.stall; s++) begin
                    @(negedge clk);
                    check_mem(v, $sformatf("v%0d_stall%0d", i, s));
                end
                mem_rvalid = 0;
                mem_ready = 1;
                @(negedge clk);
                mem_ready = 0;
                check($sformatf("v%0d_wait_mem_req", i), mem_req, 64'd0);
                mem_rvalid = 1;
                mem_rdata = v.mrd;
                @(negedge clk);
                mem_rvalid = 0;
                check($sformatf("v%0d_rv_lat", i), v.dm ? dm_rvalid : if_rvalid, 64'd1);
            end
        end

        // Abort a load in WAIT by reset; its completion must never appear.
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 32'h600; dm_load_type = 3'b010; dm_store_type = 2'b10;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dm_gnt) begin
                got = 1;
                break;
            end
        end
        check("abort_gnt", got, 64'd1);
        dm_req = 0;
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("abort_rst");
        @(negedge clk);
        reset_n = 1'b1;
        mem_rvalid = 1;
        mem_rdata = 32'hFFFFFFFF;
        rv_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_rvalid = 0;
            if (if_rvalid || dm_rvalid) rv_seen++;
        end
        check("abort_no_rvalid", rv_seen, 64'd0);

        // Both requesters held: FAIR=1 alternates starting with data, FAIR=0 always data.
        sb_en = 0;
        mem_ready = 1;
        mem_rvalid = 1;
        mem_rdata = 32'h0;
        dm_addr = 32'h500; dm_we = 0; dm_load_type = 3'b010;
        if_addr = 32'h200;
        @(negedge clk);
        if_req = 1;
        dm_req = 1;
        n0 = 0; n1 = 0; dup = 0;
        for (int k = 0; k < 40 && (n0 < 4 || n1 < 4); k++) begin
            @(negedge clk);
            if (if_gnt && dm_gnt) dup++;
            if (if_gnt_b && dm_gnt_b) dup++;
            if (if_gnt || dm_gnt) begin
                if (n0 < 4) g0[n0] = dm_gnt;
                n0++;
            end
            if (if_gnt_b || dm_gnt_b) begin
                if (n1 < 4) g1[n1] = dm_gnt_b;
                n1++;
            end
        end
        check("tie_fair_count", (n0 >= 4), 64'd1);
        check("tie_dpri_count", (n1 >= 4), 64'd1);
        check("tie_dual_gnt", dup, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_fair_%0d", i), g0[i], (i % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("tie_dpri_%0d", i), g1[i], 64'd1);
        end
        dm_req = 0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if_gnt_b) begin
                got = 1;
                break;
            end
        end
        check("dpri_fetch_after_drop", got, 64'd1);
        if_req = 0;
        repeat (6) @(negedge clk);
        mem_ready = 0;
        mem_rvalid = 0;
        @(negedge clk);

        check("sb_drain", sb_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory bus between the core's instruction-fetch requester and its load/store requester.
- Serialises the two requesters with one outstanding transaction at a time.
- Generates byte enables and replicated write data from store_type, and aligns/extends read data from load_type.
- Sits between the RV32I core and a variable-latency memory, so fetch and data access can live in one RAM.

Parameters:
- ADDR_W, 32, address width of all address ports.
- FAIR, 1: 1 = alternate grants when both sides request in the same cycle; 0 = data side always wins.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  one-cycle pulse; fetch accepted
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  32  store data, LSB-aligned
- dm_store_type  in  2  00 SB, 01 SH, 10 SW
- dm_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- dm_gnt  out  1  one-cycle pulse; data request accepted
- dm_rvalid  out  1  one-cycle pulse; load data ready or store completed
- dm_rdata  out  32  aligned, extended load data
- dm_err  out  1  qualifies dm_rvalid; misaligned access
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables (writes only; 4'b0000 on reads)
- mem_wdata  out  32  replicated write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  32  memory read word

Behaviour:
- Reset:
  - All outputs 0. State IDLE.
  - last_grant = FETCH, so the first tie goes to data.
  - Reset mid-transaction abandons the transaction; no rvalid is ever issued for it.
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - Sample if_req/dm_req at each clock edge.
  - Only one request: grant it.
  - Both requests: FAIR=1 grants the side not in last_grant; FAIR=0 grants data.
  - On grant, at the same edge:
    - pulse the matching gnt for one cycle;
    - latch the address, we, type and wdata fields;
    - update last_grant;
    - drive mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata;
    - go to ISSUE.
  - Requester may drop or change req and its fields from the cycle after gnt.
- Misaligned data access (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]≠0):
  - Granted as normal, but no memory access is made (mem_req stays 0).
  - Next cycle: dm_rvalid=1, dm_err=1, dm_rdata=0.
  - Then back to IDLE. Counts as a data grant for fairness.
- ISSUE: hold all mem_* stable while mem_ready=0. At the edge where mem_ready=1, drop mem_req and go to WAIT.
- WAIT:
  - At the edge where mem_rvalid=1, latch the result and pulse the owner's rvalid for one cycle; go to IDLE.
  - Fetch result: if_rdata = mem_rdata.
  - Load result: select byte/half by addr[1:0]/addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
  - Store result: dm_rvalid=1 marks completion; dm_rdata=0.
- Writes:
  - mem_be: SB = 1 << addr[1:0]; SH = addr[1] ? 4'b1100 : 4'b0011; SW = 4'b1111.
  - mem_wdata: SB = byte x4; SH = half x2; SW = word.
- mem_rvalid outside WAIT is ignored.
- rvalid is asserted in the cycle the arbiter re-enters IDLE, so a new request can be granted at that same edge.
- Minimum latency with mem_ready and mem_rvalid each asserted in their first legal cycle:
  - req in cycle 0
  - gnt and mem_req in cycle 1
  - WAIT in cycle 2 (mem_rvalid sampled)
  - rvalid in cycle 3
- Unknown type encodings: behave as SW/LW.
- Invariants:
  - At most one gnt and one rvalid in any cycle.
  - Exactly one rvalid per gnt, absent reset.

Test Plan:
- Fetch only, zero-wait memory: if_req with if_addr=0x100 in cycle 0 → if_gnt cycle 1; mem_req=1, mem_addr=0x100, mem_be=0 in cycle 1; mem_rvalid with rdata=0x00500093 in cycle 2 → if_rvalid=1, if_rdata=0x00500093 in cycle 3.
- Tie with FAIR=1: if_req and dm_req held high from reset → grant order data, fetch, data, fetch; FAIR=0 repeat → data granted every time until dm_req drops.
- Store SB, addr=0x203, wdata=0x000000AB → mem_be=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x200; mem_ready held low 3 cycles → mem_* stable; dm_rvalid after ack.
- Load LB vs LBU at addr=0x301, mem_rdata=0x1234F678 → dm_rdata=0xFFFFFFF6 for LB, 0x000000F6 for LBU; LH at 0x302 → 0x00001234.
- Misaligned SW at 0x402 → dm_gnt, then dm_rvalid with dm_err=1 next cycle; mem_req never asserts.
- Reset asserted during WAIT → all outputs 0 immediately; later mem_rvalid is ignored; no if_rvalid/dm_rvalid; next tie grants data.
